// File: rtl/tile_conv_seq.sv
// Sequential tile convolver: one MAC per cycle over each FxF tile, one saturated result per tile on valid/ready.
// Define TILE_CONV_RELU_EN to clamp negative results to zero.
module tile_conv_seq #(
    parameter int SIZE        = 9,
    parameter int FILTER_SIZE = 3,
    parameter int DATA_W      = 32,
    localparam int F          = FILTER_SIZE,
    localparam int NT         = (SIZE / FILTER_SIZE) * (SIZE / FILTER_SIZE),
    localparam int IW         = (NT > 1) ? $clog2(NT) : 1
) (
    input  logic                                      clk,
    input  logic                                      rst,
    input  logic                                      start,
    input  logic [0:NT-1][0:F-1][0:F-1][DATA_W-1:0]   tiles_in,
    input  logic [0:F-1][0:F-1][DATA_W-1:0]           kernel,
    output logic                                      busy,
    output logic                                      done,
    output logic                                      out_valid,
    input  logic                                      out_ready,
    output logic [DATA_W-1:0]                         out_data,
    output logic [IW-1:0]                             out_idx
);

    localparam int N  = F * F;
    localparam int EW = (N > 1) ? $clog2(N) : 1;
    localparam int PW = 2 * DATA_W;
    localparam int AW = PW + $clog2(N);

    localparam logic [EW-1:0] ELAST = EW'(N - 1);
    localparam logic [IW-1:0] TLAST = IW'(NT - 1);

    localparam logic signed [AW-1:0] SMAX = {{(AW-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
    localparam logic signed [AW-1:0] SMIN = {{(AW-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

    typedef enum logic [1:0] {S_IDLE, S_MAC, S_HOLD} state_t;

    state_t                              state_q;
    // Snapshot stored row-major per tile so elem_cnt indexes it directly
    logic [0:NT-1][0:N-1][DATA_W-1:0]    tile_q;
    logic [0:N-1][DATA_W-1:0]            kern_q;
    logic [EW-1:0]                       elem_cnt_q;
    logic [IW-1:0]                       tile_cnt_q;
    logic signed [AW-1:0]                acc_q;
    logic signed [AW-1:0]                acc_d;

    logic signed [DATA_W-1:0]            pix;
    logic signed [DATA_W-1:0]            wt;
    logic signed [PW-1:0]                pix_x;
    logic signed [PW-1:0]                wt_x;
    logic signed [PW-1:0]                prod;

    function automatic logic [DATA_W-1:0] saturate(input logic signed [AW-1:0] a);
        if (a > SMAX)
            return SMAX[DATA_W-1:0];
        else if (a < SMIN)
            return SMIN[DATA_W-1:0];
        else
            return a[DATA_W-1:0];
    endfunction

    function automatic logic [DATA_W-1:0] shape(input logic [DATA_W-1:0] v);
`ifdef TILE_CONV_RELU_EN
        return v[DATA_W-1] ? '0 : v;
`else
        return v;
`endif
    endfunction

    assign pix   = tile_q[tile_cnt_q][elem_cnt_q];
    assign wt    = kern_q[elem_cnt_q];
    assign pix_x = {{DATA_W{pix[DATA_W-1]}}, pix};
    assign wt_x  = {{DATA_W{wt[DATA_W-1]}}, wt};
    assign prod  = pix_x * wt_x;
    assign acc_d = acc_q + {{(AW-PW){prod[PW-1]}}, prod};

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            busy       <= 1'b0;
            done       <= 1'b0;
            out_valid  <= 1'b0;
            out_data   <= '0;
            out_idx    <= '0;
            acc_q      <= '0;
            elem_cnt_q <= '0;
            tile_cnt_q <= '0;
        end else begin
            done <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        tile_q     <= tiles_in;
                        kern_q     <= kernel;
                        acc_q      <= '0;
                        elem_cnt_q <= '0;
                        tile_cnt_q <= '0;
                        busy       <= 1'b1;
                        state_q    <= S_MAC;
                    end
                end
                S_MAC: begin
                    acc_q      <= acc_d;
                    elem_cnt_q <= elem_cnt_q + 1'b1;
                    if (elem_cnt_q == ELAST) begin
                        out_data  <= shape(saturate(acc_d));
                        out_idx   <= tile_cnt_q;
                        out_valid <= 1'b1;
                        state_q   <= S_HOLD;
                    end
                end
                S_HOLD: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        if (tile_cnt_q == TLAST) begin
                            done    <= 1'b1;
                            busy    <= 1'b0;
                            state_q <= S_IDLE;
                        end else begin
                            tile_cnt_q <= tile_cnt_q + 1'b1;
                            acc_q      <= '0;
                            elem_cnt_q <= '0;
                            state_q    <= S_MAC;
                        end
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_tile_conv_seq.sv
// Self-checking bench for tile_conv_seq (SIZE=9, F=3, DATA_W=32): constant vectors, hand sequences, random frames vs a reference model.
module tb_tile_conv_seq;

    localparam int NT = 9;
    localparam int F  = 3;
    localparam int W  = 32;
    localparam int IW = 4;

    logic clk = 1'b0;
    logic rst, start, out_ready;
    logic busy, done, out_valid;
    logic [0:NT-1][0:F-1][0:F-1][W-1:0] tiles;
    logic [0:F-1][0:F-1][W-1:0]         kern;
    logic [W-1:0]  out_data;
    logic [IW-1:0] out_idx;

    int n_checks = 0;
    int n_err    = 0;

    typedef logic [W-1:0] exp_t [NT];
    logic [W-1:0]  res_q[$];
    logic [IW-1:0] idx_q[$];

    typedef struct {
        logic [W-1:0] pix;
        logic [W-1:0] wt;
        int           mode;
        int           exp_first;
        int           exp_done;
        logic [W-1:0] exp;
    } vec_t;

    vec_t tbl [6];

    tile_conv_seq #(.SIZE(9), .FILTER_SIZE(3), .DATA_W(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .tiles_in  (tiles),
        .kernel    (kern),
        .busy      (busy),
        .done      (done),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_idx   (out_idx)
    );

    always #5 clk = ~clk;

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endfunction

    function automatic logic [W-1:0] ref_sat(input logic signed [71:0] s);
        logic [W-1:0] v;
        if (s > 72'sd2147483647)
            v = 32'h7FFF_FFFF;
        else if (s < -72'sd2147483648)
            v = 32'h8000_0000;
        else
            v = s[W-1:0];
`ifdef TILE_CONV_RELU_EN
        if (v[W-1]) v = '0;
`endif
        return v;
    endfunction

    // Plain dot product of every tile with the kernel, wide enough never to overflow
    function automatic void ref_model(output exp_t e);
        logic signed [71:0] s;
        for (int t = 0; t < NT; t++) begin
            s = '0;
            for (int r = 0; r < F; r++)
                for (int c = 0; c < F; c++)
                    s = s + (longint'($signed(tiles[t][r][c])) * longint'($signed(kern[r][c])));
            e[t] = ref_sat(s);
        end
    endfunction

    function automatic logic [W-1:0] rnd_val(input int kind);
        case (kind)
            0: return 32'($urandom_range(0, 2000)) - 32'd1000;
            1: return $urandom();
            default: begin
                case ($urandom_range(0, 3))
                    0: return 32'h7FFF_FFFF;
                    1: return 32'h8000_0000;
                    default: return 32'($urandom_range(0, 200)) - 32'd100;
                endcase
            end
        endcase
    endfunction

    task automatic fill(input logic [W-1:0] p, input logic [W-1:0] w);
        for (int t = 0; t < NT; t++)
            for (int r = 0; r < F; r++)
                for (int c = 0; c < F; c++)
                    tiles[t][r][c] = p;
        for (int r = 0; r < F; r++)
            for (int c = 0; c < F; c++)
                kern[r][c] = w;
    endtask

    task automatic fill_random(input int kind);
        for (int t = 0; t < NT; t++)
            for (int r = 0; r < F; r++)
                for (int c = 0; c < F; c++)
                    tiles[t][r][c] = rnd_val(kind);
        for (int r = 0; r < F; r++)
            for (int c = 0; c < F; c++)
                kern[r][c] = rnd_val(kind);
    endtask

    // mode 0: ready high; 1: random ready; 2: ready low 5 cycles in tile 2 HOLD
    task automatic run_frame(input int mode, input bit scramble, output int first_lat, output int done_lat);
        int e, bp;
        bit hold_prev;
        logic [W-1:0]  pd;
        logic [IW-1:0] pi;
        res_q.delete();
        idx_q.delete();
        first_lat = -1;
        done_lat  = -1;
        bp        = 0;
        hold_prev = 1'b0;
        pd        = '0;
        pi        = '0;
        @(negedge clk);
        start     = 1'b1;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        if (!scramble) start = 1'b0;
        e = 0;
        while (e < 3000) begin
            if (scramble) begin
                fill_random(1);
                start = 1'($urandom_range(0, 1));
            end
            if (hold_prev) begin
                chk("hold_valid", 64'(out_valid), 64'd1);
                chk("hold_data", 64'(out_data), 64'(pd));
                chk("hold_idx", 64'(out_idx), 64'(pi));
            end
            if (out_valid && first_lat < 0) first_lat = e;
            if (done) begin
                done_lat = e;
                break;
            end
            case (mode)
                0: out_ready = 1'b1;
                1: out_ready = 1'($urandom_range(0, 1));
                default: begin
                    if (out_valid && out_idx == 4'd2 && bp < 5) begin
                        out_ready = 1'b0;
                        bp++;
                    end else begin
                        out_ready = 1'b1;
                    end
                end
            endcase
            if (out_valid && out_ready) begin
                res_q.push_back(out_data);
                idx_q.push_back(out_idx);
                hold_prev = 1'b0;
            end else begin
                hold_prev = out_valid;
                pd = out_data;
                pi = out_idx;
            end
            @(posedge clk);
            #1;
            e++;
        end
        start = 1'b0;
        chk("frame_completes", 64'(done_lat >= 0), 64'd1);
    endtask

    task automatic check_frame(input string tag, input exp_t e);
        chk({tag, "_count"}, 64'(res_q.size()), 64'(NT));
        for (int k = 0; k < res_q.size() && k < NT; k++) begin
            chk({tag, "_idx"}, 64'(idx_q[k]), 64'(k));
            chk({tag, "_data"}, 64'(res_q[k]), 64'(e[k]));
        end
    endtask

    task automatic check_after_done(input string tag);
        @(posedge clk);
        #1;
        chk({tag, "_done_pulse"}, 64'(done), 64'd0);
        chk({tag, "_busy_low"}, 64'(busy), 64'd0);
    endtask

    task automatic check_outputs_zero(input string tag);
        chk({tag, "_busy"}, 64'(busy), 64'd0);
        chk({tag, "_done"}, 64'(done), 64'd0);
        chk({tag, "_valid"}, 64'(out_valid), 64'd0);
        chk({tag, "_data"}, 64'(out_data), 64'd0);
        chk({tag, "_idx"}, 64'(out_idx), 64'd0);
    endtask

    initial begin
        exp_t ex;
        int fl, dl;
        bit seen;

        tbl[0] = '{32'd1, 32'd1, 0, 9, 90, 32'd9};
        tbl[1] = '{32'd1, 32'd1, 2, 9, 95, 32'd9};
        tbl[2] = '{32'h7FFF_FFFF, 32'h7FFF_FFFF, 0, 9, 90, 32'h7FFF_FFFF};
`ifdef TILE_CONV_RELU_EN
        tbl[3] = '{32'h7FFF_FFFF, 32'h8000_0000, 1, 9, -1, 32'h0};
        tbl[4] = '{32'hFFFF_FFFF, 32'd1, 1, 9, -1, 32'h0};
`else
        tbl[3] = '{32'h7FFF_FFFF, 32'h8000_0000, 1, 9, -1, 32'h8000_0000};
        tbl[4] = '{32'hFFFF_FFFF, 32'd1, 1, 9, -1, 32'hFFFF_FFF7};
`endif
        tbl[5] = '{32'd5, 32'd7, 0, 9, 90, 32'd315};

        rst = 1'b1;
        start = 1'b0;
        out_ready = 1'b0;
        tiles = '0;
        kern = '0;
        repeat (3) @(posedge clk);
        #1;
        check_outputs_zero("reset");
        rst = 1'b0;

        for (int i = 0; i < 6; i++) begin
            fill(tbl[i].pix, tbl[i].wt);
            for (int k = 0; k < NT; k++) ex[k] = tbl[i].exp;
            run_frame(tbl[i].mode, 1'b0, fl, dl);
            chk($sformatf("vec%0d_first_valid", i), 64'(fl), 64'(tbl[i].exp_first));
            if (tbl[i].exp_done >= 0)
                chk($sformatf("vec%0d_done_edge", i), 64'(dl), 64'(tbl[i].exp_done));
            check_frame($sformatf("vec%0d", i), ex);
            check_after_done($sformatf("vec%0d", i));
        end

        // Ordering: pixel(row,col)=row*9+col, one-hot centre weight
        for (int t = 0; t < NT; t++)
            for (int r = 0; r < F; r++)
                for (int c = 0; c < F; c++)
                    tiles[t][r][c] = 32'(((t / 3) * 3 + r) * 9 + (t % 3) * 3 + c);
        kern = '0;
        kern[1][1] = 32'd1;
        ex = '{32'd10, 32'd13, 32'd16, 32'd37, 32'd40, 32'd43, 32'd64, 32'd67, 32'd70};
        run_frame(0, 1'b0, fl, dl);
        check_frame("order", ex);
        start = 1'b1;
        @(posedge clk);
        #1;
        chk("restart_after_done", 64'(busy), 64'd1);
        chk("restart_done_pulse", 64'(done), 64'd0);
        start = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check_outputs_zero("restart_reset");

        // Snapshot: inputs and start churn while busy
        fill_random(2);
        ref_model(ex);
        run_frame(1, 1'b1, fl, dl);
        check_frame("snapshot", ex);
        seen = 1'b0;
        repeat (12) begin
            @(posedge clk);
            #1;
            if (busy || out_valid) seen = 1'b1;
        end
        chk("snapshot_single_frame", 64'(seen), 64'd0);

        // Reset during tile 4 MAC
        fill(32'd1, 32'd1);
        @(negedge clk);
        start = 1'b1;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 200 && !seen; i++) begin
            if (out_valid && out_idx == 4'd3) seen = 1'b1;
            @(posedge clk);
            #1;
        end
        chk("abort_reached_tile4", 64'(seen), 64'd1);
        repeat (3) @(posedge clk);
        #1;
        chk("abort_busy_before", 64'(busy), 64'd1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check_outputs_zero("abort");
        for (int k = 0; k < NT; k++) ex[k] = 32'd9;
        run_frame(0, 1'b0, fl, dl);
        chk("abort_fresh_first", 64'(fl), 64'd9);
        chk("abort_fresh_done", 64'(dl), 64'd90);
        check_frame("abort_fresh", ex);
        check_after_done("abort_fresh");

        for (int i = 0; i < 6; i++) begin
            fill_random(i % 3);
            ref_model(ex);
            run_frame(1, 1'b0, fl, dl);
            chk($sformatf("rand%0d_first_valid", i), 64'(fl), 64'd9);
            check_frame($sformatf("rand%0d", i), ex);
            check_after_done($sformatf("rand%0d", i));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
